// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared encodings, default timing constants and digit helpers
//                for the three-source display arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Owner / state encoding; the same code is presented on the src output
    localparam logic [1:0] c_ST_MEAS = 2'b00;
    localparam logic [1:0] c_ST_SET  = 2'b01;
    localparam logic [1:0] c_ST_DIAG = 2'b10;

    // Default timing constants, in 1 Hz ticks
    localparam int c_SET_TIMEOUT_S_DEF = 10;
    localparam int c_DIAG_MIN_S_DEF    = 3;

    // Three BCD digits as one bundle (hundreds, tens, units)
    typedef struct packed {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
    } digits_t;

    // Clamp a single digit into the displayable BCD range
    function automatic logic [3:0] sat9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_arbiter_if
//  Description : Source request/data bundle and display-side outputs of the
//                display arbiter. master = sources/display, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface display_arbiter_if;

    logic       meas_valid;
    logic [3:0] meas_h;
    logic [3:0] meas_t;
    logic [3:0] meas_u;

    logic       set_req;
    logic [3:0] set_h;
    logic [3:0] set_t;
    logic [3:0] set_u;

    logic       diag_req;
    logic [3:0] diag_h;
    logic [3:0] diag_t;
    logic [3:0] diag_u;

    logic [3:0] data_h;
    logic [3:0] data_t;
    logic [3:0] data_u;
    logic [1:0] src;
    logic       set_gnt;
    logic       diag_gnt;
    logic       set_timeout;

    modport master (
        output meas_valid, meas_h, meas_t, meas_u,
        output set_req, set_h, set_t, set_u,
        output diag_req, diag_h, diag_t, diag_u,
        input  data_h, data_t, data_u, src, set_gnt, diag_gnt, set_timeout
    );

    modport slave (
        input  meas_valid, meas_h, meas_t, meas_u,
        input  set_req, set_h, set_t, set_u,
        input  diag_req, diag_h, diag_t, diag_u,
        output data_h, data_t, data_u, src, set_gnt, diag_gnt, set_timeout
    );

endinterface
`default_nettype wire

// File: rtl/sec_tick.sv
`default_nettype none
// ============================================================================
//  Module      : sec_tick
//  Description : Rising-edge detector for the 1 Hz square wave, producing a
//                single clk_100MHz-cycle tick per second. clk_1Hz is expected
//                to be generated in (or already synchronised to) this domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module sec_tick (
    input  wire logic clk_100MHz,
    input  wire logic reset,
    input  wire logic clk_1Hz,
    output logic      tick
);

    logic r_prev;

    // History of the 1 Hz level from the previous system cycle
    always_ff @(posedge clk_100MHz) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= clk_1Hz;
    end

    assign tick = clk_1Hz & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : display_arbiter
//  Description : Arbitrates a 3-digit display between the live measurement,
//                the setpoint editor (with inactivity timeout) and a
//                diagnostic source (highest priority, minimum hold time).
//  Revision    : 1.0 - initial release
// ============================================================================
module display_arbiter
    import display_pkg::*;
#(
    parameter int SET_TIMEOUT_S = c_SET_TIMEOUT_S_DEF,
    parameter int DIAG_MIN_S    = c_DIAG_MIN_S_DEF
) (
    input  wire logic         clk_100MHz,
    input  wire logic         reset,
    input  wire logic         clk_1Hz,
    display_arbiter_if.slave  bus
);

    localparam int c_SET_W  = (SET_TIMEOUT_S < 1) ? 1 : $clog2(SET_TIMEOUT_S + 1);
    localparam int c_DIAG_W = (DIAG_MIN_S < 1)    ? 1 : $clog2(DIAG_MIN_S + 1);
    localparam logic [c_SET_W-1:0]  c_SET_LIMIT  = c_SET_W'(SET_TIMEOUT_S);
    localparam logic [c_DIAG_W-1:0] c_DIAG_LIMIT = c_DIAG_W'(DIAG_MIN_S);

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic                w_fire;
    logic                w_tick;
    logic                r_armed;
    logic [c_SET_W-1:0]  r_set_cnt;
    logic [c_DIAG_W-1:0] r_diag_cnt;
    digits_t             r_shadow;
    digits_t             r_set_prev;
    digits_t             w_set_now;
    digits_t             w_disp;
    digits_t             r_data;
    logic                w_set_changed;
    logic [1:0]          r_src;
    logic                r_set_gnt;
    logic                r_diag_gnt;
    logic                r_set_timeout;

    sec_tick u_sec_tick (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clk_1Hz    (clk_1Hz),
        .tick       (w_tick)
    );

    assign w_set_now     = '{h: bus.set_h, t: bus.set_t, u: bus.set_u};
    assign w_set_changed = (w_set_now != r_set_prev);

    // Ownership decision: DIAG preempts everything, then SET/MEAS rules
    always_comb begin
        w_next = r_state;
        w_fire = 1'b0;
        if (bus.diag_req) begin
            w_next = c_ST_DIAG;
        end else begin
            case (r_state)
                c_ST_MEAS: begin
                    if (bus.set_req && r_armed) w_next = c_ST_SET;
                end
                c_ST_SET: begin
                    if (!bus.set_req) begin
                        w_next = c_ST_MEAS;
                    end else if (r_set_cnt >= c_SET_LIMIT) begin
                        w_next = c_ST_MEAS;
                        w_fire = 1'b1;
                    end
                end
                c_ST_DIAG: begin
                    if (r_diag_cnt >= c_DIAG_LIMIT)
                        w_next = (bus.set_req && r_armed) ? c_ST_SET : c_ST_MEAS;
                end
                default: w_next = c_ST_MEAS;
            endcase
        end
    end

    // Source selection for the display; a fresh measurement bypasses the shadow
    always_comb begin
        w_disp = r_shadow;
        case (r_state)
            c_ST_MEAS: w_disp = bus.meas_valid ? '{h: bus.meas_h, t: bus.meas_t, u: bus.meas_u}
                                               : r_shadow;
            c_ST_SET:  w_disp = '{h: sat9(bus.set_h), t: sat9(bus.set_t), u: sat9(bus.set_u)};
            c_ST_DIAG: w_disp = '{h: bus.diag_h, t: bus.diag_t, u: bus.diag_u};
            default:   w_disp = r_shadow;
        endcase
    end

    // State register and registered owner decodes
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state       <= c_ST_MEAS;
            r_src         <= c_ST_MEAS;
            r_set_gnt     <= 1'b0;
            r_diag_gnt    <= 1'b0;
            r_set_timeout <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_src         <= w_next;
            r_set_gnt     <= (w_next == c_ST_SET);
            r_diag_gnt    <= (w_next == c_ST_DIAG);
            r_set_timeout <= w_fire;
        end
    end

    // SET arming: a timeout disarms, any cycle with set_req low re-arms
    always_ff @(posedge clk_100MHz) begin
        if (reset)             r_armed <= 1'b1;
        else if (w_fire)       r_armed <= 1'b0;
        else if (!bus.set_req) r_armed <= 1'b1;
    end

    // SET inactivity counter: counts only while SET is the (new) owner, frozen under DIAG
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_set_cnt <= '0;
        end else if (w_next == c_ST_SET) begin
            if (w_set_changed)
                r_set_cnt <= '0;
            else if (w_tick && (r_set_cnt < c_SET_LIMIT))
                r_set_cnt <= r_set_cnt + c_SET_W'(1);
        end else if (w_next == c_ST_MEAS) begin
            r_set_cnt <= '0;
        end
    end

    // DIAG hold counter: cleared on entry, counts ticks while DIAG stays owner
    always_ff @(posedge clk_100MHz) begin
        if (reset || (w_next != c_ST_DIAG) || (r_state != c_ST_DIAG))
            r_diag_cnt <= '0;
        else if (w_tick && (r_diag_cnt < c_DIAG_LIMIT))
            r_diag_cnt <= r_diag_cnt + c_DIAG_W'(1);
    end

    // Measurement shadow, previous setpoint digits and registered display data
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_shadow   <= '0;
            r_set_prev <= '0;
            r_data     <= '0;
        end else begin
            if (bus.meas_valid)
                r_shadow <= '{h: bus.meas_h, t: bus.meas_t, u: bus.meas_u};
            r_set_prev <= w_set_now;
            r_data     <= w_disp;
        end
    end

    assign bus.data_h      = r_data.h;
    assign bus.data_t      = r_data.t;
    assign bus.data_u      = r_data.u;
    assign bus.src         = r_src;
    assign bus.set_gnt     = r_set_gnt;
    assign bus.diag_gnt    = r_diag_gnt;
    assign bus.set_timeout = r_set_timeout;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_arbiter
//  Description : Self-checking bench for display_arbiter: directed scenarios
//                plus randomized traffic against a behavioural owner model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_arbiter;

    localparam int TIMEOUT_S = 10;
    localparam int DIAG_S    = 3;

    logic clk;
    logic reset;
    logic clk_1hz;

    display_arbiter_if bus ();

    display_arbiter dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .clk_1Hz    (clk_1hz),
        .bus        (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // owner: 0 = measurement, 1 = setpoint, 2 = diagnostic
    int          m_owner;
    int          m_set_secs;
    int          m_diag_secs;
    bit          m_armed;
    bit          m_last_1hz;
    bit          m_timeout;
    logic [11:0] m_shadow;
    logic [11:0] m_last_set;
    logic [11:0] m_data;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 9) ? 4'd9 : d;
    endfunction

    task automatic model_update();
        bit          tick;
        bit          changed;
        bit          fire;
        int          nxt;
        logic [11:0] setd;
        logic [11:0] shown;
        tick       = clk_1hz && !m_last_1hz;
        m_last_1hz = clk_1hz;
        if (reset) begin
            m_owner = 0; m_set_secs = 0; m_diag_secs = 0; m_armed = 1;
            m_last_1hz = 0; m_timeout = 0; m_shadow = '0; m_last_set = '0; m_data = '0;
            return;
        end
        setd    = {bus.set_h, bus.set_t, bus.set_u};
        changed = (setd != m_last_set);
        m_last_set = setd;
        if (m_owner == 0)      shown = bus.meas_valid ? {bus.meas_h, bus.meas_t, bus.meas_u} : m_shadow;
        else if (m_owner == 1) shown = {clamp_digit(bus.set_h), clamp_digit(bus.set_t), clamp_digit(bus.set_u)};
        else                   shown = {bus.diag_h, bus.diag_t, bus.diag_u};
        if (bus.meas_valid) m_shadow = {bus.meas_h, bus.meas_t, bus.meas_u};
        fire = 0;
        nxt  = m_owner;
        if (bus.diag_req) nxt = 2;
        else if (m_owner == 0) nxt = (bus.set_req && m_armed) ? 1 : 0;
        else if (m_owner == 1) begin
            if (!bus.set_req) nxt = 0;
            else if (m_set_secs >= TIMEOUT_S) begin nxt = 0; fire = 1; end
        end else if (m_diag_secs >= DIAG_S) nxt = (bus.set_req && m_armed) ? 1 : 0;
        if (fire) m_armed = 0;
        else if (!bus.set_req) m_armed = 1;
        if (nxt == 1)      m_set_secs = changed ? 0 : m_set_secs + int'(tick);
        else if (nxt == 0) m_set_secs = 0;
        if (nxt == 2) m_diag_secs = (m_owner != 2) ? 0 : m_diag_secs + int'(tick);
        else          m_diag_secs = 0;
        m_timeout = fire;
        m_owner   = nxt;
        m_data    = shown;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic pulse_1hz();
        clk_1hz = 1'b1;
        step();
        clk_1hz = 1'b0;
        step();
    endtask

    task automatic clear_inputs();
        bus.meas_valid = 0; bus.meas_h = 0; bus.meas_t = 0; bus.meas_u = 0;
        bus.set_req = 0;    bus.set_h = 0;  bus.set_t = 0;  bus.set_u = 0;
        bus.diag_req = 0;   bus.diag_h = 0; bus.diag_t = 0; bus.diag_u = 0;
        clk_1hz = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        bus.diag_req = 1; bus.diag_h = 4'h7; bus.diag_t = 4'h7; bus.diag_u = 4'h7;
        step(); step();
        reset = 1'b1;
        step();
        n_tests++;
        if ({bus.data_h, bus.data_t, bus.data_u} !== 12'h000) begin
            n_fail++; $display("FAIL reset_data: got %h want 000", {bus.data_h, bus.data_t, bus.data_u});
        end
        n_tests++;
        if ({bus.src, bus.set_gnt, bus.diag_gnt, bus.set_timeout} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_ctrl: got src=%b sg=%b dg=%b to=%b want 00 0 0 0",
                               bus.src, bus.set_gnt, bus.diag_gnt, bus.set_timeout);
        end
        reset = 1'b0;
        clear_inputs();
        step();
    endtask

    task automatic test_meas();
        do_reset();
        bus.meas_valid = 1; bus.meas_h = 1; bus.meas_t = 2; bus.meas_u = 3;
        step();
        bus.meas_valid = 0; bus.meas_h = 0; bus.meas_t = 0; bus.meas_u = 0;
        n_tests++;
        if ({bus.data_h, bus.data_t, bus.data_u} !== 12'h123 || bus.src !== 2'b00) begin
            n_fail++; $display("FAIL meas_pass: got data=%h src=%b want 123 00",
                               {bus.data_h, bus.data_t, bus.data_u}, bus.src);
        end
        step();
        n_tests++;
        if ({bus.data_h, bus.data_t, bus.data_u} !== 12'h123) begin
            n_fail++; $display("FAIL meas_shadow: got %h want 123", {bus.data_h, bus.data_t, bus.data_u});
        end
    endtask

    task automatic test_set_grant();
        do_reset();
        bus.set_req = 1; bus.set_h = 4; bus.set_t = 5; bus.set_u = 4'hC;
        step();
        n_tests++;
        if (bus.set_gnt !== 1'b1 || bus.src !== 2'b01) begin
            n_fail++; $display("FAIL set_grant: got sg=%b src=%b want 1 01", bus.set_gnt, bus.src);
        end
        step();
        n_tests++;
        if ({bus.data_h, bus.data_t, bus.data_u} !== 12'h459) begin
            n_fail++; $display("FAIL set_clamp: got %h want 459", {bus.data_h, bus.data_t, bus.data_u});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.set_req = 1; bus.set_h = 7; bus.set_t = 7; bus.set_u = 7;
        step();
        for (int i = 0; i < TIMEOUT_S - 1; i++) pulse_1hz();
        n_tests++;
        if (bus.set_timeout !== 1'b0 || bus.src !== 2'b01) begin
            n_fail++; $display("FAIL timeout_early: got to=%b src=%b want 0 01", bus.set_timeout, bus.src);
        end
        pulse_1hz();
        n_tests++;
        if (bus.set_timeout !== 1'b1 || bus.src !== 2'b00 || bus.set_gnt !== 1'b0) begin
            n_fail++; $display("FAIL timeout_fire: got to=%b src=%b sg=%b want 1 00 0",
                               bus.set_timeout, bus.src, bus.set_gnt);
        end
        step();
        n_tests++;
        if (bus.set_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_width: got %b want 0", bus.set_timeout);
        end
        step(); step();
        n_tests++;
        if (bus.set_gnt !== 1'b0) begin
            n_fail++; $display("FAIL timeout_disarm: got sg=%b want 0", bus.set_gnt);
        end
        bus.set_req = 0;
        step();
        bus.set_req = 1;
        step();
        n_tests++;
        if (bus.set_gnt !== 1'b1) begin
            n_fail++; $display("FAIL timeout_rearm: got sg=%b want 1", bus.set_gnt);
        end
    endtask

    task automatic test_diag_preempt();
        do_reset();
        bus.set_req = 1; bus.set_h = 1; bus.set_t = 0; bus.set_u = 5;
        bus.diag_h = 4'hE; bus.diag_t = 4'h0; bus.diag_u = 4'h2;
        step();
        for (int i = 0; i < 4; i++) pulse_1hz();
        bus.diag_req = 1;
        step();
        bus.diag_req = 0;
        n_tests++;
        if (bus.diag_gnt !== 1'b1 || bus.set_gnt !== 1'b0 || bus.src !== 2'b10) begin
            n_fail++; $display("FAIL preempt_enter: got dg=%b sg=%b src=%b want 1 0 10",
                               bus.diag_gnt, bus.set_gnt, bus.src);
        end
        pulse_1hz(); pulse_1hz();
        n_tests++;
        if (bus.src !== 2'b10) begin
            n_fail++; $display("FAIL preempt_hold: got src=%b want 10", bus.src);
        end
        pulse_1hz();
        n_tests++;
        if (bus.src !== 2'b01 || bus.set_gnt !== 1'b1) begin
            n_fail++; $display("FAIL preempt_resume: got src=%b sg=%b want 01 1", bus.src, bus.set_gnt);
        end
        for (int i = 0; i < 5; i++) pulse_1hz();
        n_tests++;
        if (bus.set_timeout !== 1'b0 || bus.src !== 2'b01) begin
            n_fail++; $display("FAIL preempt_frozen: got to=%b src=%b want 0 01", bus.set_timeout, bus.src);
        end
        pulse_1hz();
        n_tests++;
        if (bus.set_timeout !== 1'b1 || bus.src !== 2'b00) begin
            n_fail++; $display("FAIL preempt_timeout: got to=%b src=%b want 1 00", bus.set_timeout, bus.src);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.diag_h = 2; bus.diag_t = 0; bus.diag_u = 7;
        bus.set_h = 3; bus.set_t = 3; bus.set_u = 3;
        bus.diag_req = 1; bus.set_req = 1;
        step();
        n_tests++;
        if (bus.src !== 2'b10 || bus.set_gnt !== 1'b0 || bus.diag_gnt !== 1'b1) begin
            n_fail++; $display("FAIL simul_owner: got src=%b sg=%b dg=%b want 10 0 1",
                               bus.src, bus.set_gnt, bus.diag_gnt);
        end
        bus.meas_valid = 1; bus.meas_h = 8; bus.meas_t = 6; bus.meas_u = 1;
        step();
        bus.meas_valid = 0;
        n_tests++;
        if ({bus.data_h, bus.data_t, bus.data_u} !== 12'h207) begin
            n_fail++; $display("FAIL simul_diag_data: got %h want 207", {bus.data_h, bus.data_t, bus.data_u});
        end
        bus.diag_req = 0; bus.set_req = 0;
        for (int i = 0; i < DIAG_S; i++) pulse_1hz();
        n_tests++;
        if (bus.src !== 2'b00) begin
            n_fail++; $display("FAIL simul_exit: got src=%b want 00", bus.src);
        end
        step();
        n_tests++;
        if ({bus.data_h, bus.data_t, bus.data_u} !== 12'h861) begin
            n_fail++; $display("FAIL simul_shadow: got %h want 861", {bus.data_h, bus.data_t, bus.data_u});
        end
    endtask

    task automatic test_reset_mid_diag();
        do_reset();
        bus.set_req = 1; bus.diag_req = 1; bus.diag_h = 5; bus.diag_t = 5; bus.diag_u = 5;
        step(); step(); pulse_1hz();
        reset = 1'b1;
        step();
        n_tests++;
        if ({bus.data_h, bus.data_t, bus.data_u, bus.src, bus.set_gnt, bus.diag_gnt, bus.set_timeout} !== 17'h0) begin
            n_fail++; $display("FAIL midreset_out: got data=%h src=%b sg=%b dg=%b to=%b want all 0",
                               {bus.data_h, bus.data_t, bus.data_u}, bus.src, bus.set_gnt,
                               bus.diag_gnt, bus.set_timeout);
        end
        reset = 1'b0; bus.diag_req = 0; bus.set_req = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (bus.set_timeout !== 1'b0) begin
                n_fail++; $display("FAIL midreset_timeout: got %b want 0", bus.set_timeout);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 5000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            if (bus.set_req) begin if ($urandom_range(0, 199) == 0) bus.set_req = 0; end
            else if ($urandom_range(0, 19) == 0) bus.set_req = 1;
            if (bus.diag_req) begin if ($urandom_range(0, 14) == 0) bus.diag_req = 0; end
            else if ($urandom_range(0, 149) == 0) bus.diag_req = 1;
            if ($urandom_range(0, 99) == 0) {bus.set_h, bus.set_t, bus.set_u} = 12'($urandom);
            if ($urandom_range(0, 49) == 0) {bus.diag_h, bus.diag_t, bus.diag_u} = 12'($urandom);
            if ($urandom_range(0, 1) == 0) clk_1hz = ~clk_1hz;
            bus.meas_valid = ($urandom_range(0, 7) == 0);
            {bus.meas_h, bus.meas_t, bus.meas_u} = 12'($urandom);
            step();
            n_tests++;
            if ({bus.data_h, bus.data_t, bus.data_u} !== m_data || bus.src !== 2'(m_owner) ||
                bus.set_gnt !== (m_owner == 1) || bus.diag_gnt !== (m_owner == 2) ||
                bus.set_timeout !== m_timeout) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got data=%h src=%b sg=%b dg=%b to=%b want data=%h src=%0d to=%b",
                         c, {bus.data_h, bus.data_t, bus.data_u}, bus.src, bus.set_gnt, bus.diag_gnt,
                         bus.set_timeout, m_data, m_owner, m_timeout);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        step();
        test_reset();
        test_meas();
        test_set_grant();
        test_timeout();
        test_diag_preempt();
        test_simultaneous();
        test_reset_mid_diag();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
